// File: rtl/sigma_16p_expand.sv
// -----------------------------------------------------------------------------
// sigma_16p_expand
//
// Reverse-direction partner of the 16-point accumulator stage. Each block sum
// presented with a syn_in strobe is expanded back into 16 sign-magnitude
// samples. The samples are linearly interpolated from the previous block
// average towards the current one. Each sample is paired with one period of
// the square-wave sample clock syn_out, so data_out/syn_out can drive a
// 16-point accumulator input directly.
//
// Parameters:
//   HALF_PER  clk cycles per syn_out half period (2..255)
//
// Ports:
//   clk       system clock, rising edge
//   res       asynchronous active-low reset
//   data_in   12-bit two's-complement block sum (-2032..+2032)
//   syn_in    one-clock strobe, data_in valid in the same cycle
//   data_out  8-bit sign-magnitude sample (bit7 sign, bits6:0 magnitude)
//   syn_out   sample clock; data_out is stable across each rising edge
//   busy      high while a frame is being played out
//   ovf       sticky flag: a pending block sum was overwritten
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sigma_16p_expand #(
   parameter int HALF_PER = 10
) (
   input  logic        clk,
   input  logic        res,
   input  logic [11:0] data_in,
   input  logic        syn_in,
   output logic [7:0]  data_out,
   output logic        syn_out,
   output logic        busy,
   output logic        ovf
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             state, state_d;
   logic signed [11:0] prev, prev_d;
   logic signed [11:0] cur, cur_d;
   logic        [11:0] pend, pend_d;
   logic               pend_v, pend_v_d;
   logic        [3:0]  k, k_d;
   logic signed [16:0] acc, acc_d;
   logic        [7:0]  hcnt, hcnt_d;
   logic               syn_d;
   logic        [7:0]  dout_d;
   logic               ovf_d;

   logic signed [12:0] delta;
   logic signed [16:0] acc_step;
   logic signed [16:0] acc_load;
   logic               wrap;
   logic               consume;

   // Interpolation step between the two block sums held in prev/cur.
   assign delta    = {cur[11], cur} - {prev[11], prev};
   assign acc_step = acc + {{4{delta[12]}}, delta};

   // On a frame load prev takes the old cur, so the new start value is cur*16.
   assign acc_load = {cur[11], cur, 4'b0000};

   assign wrap = (hcnt == 8'(HALF_PER - 1));
   assign busy = (state == RUN);

   // Sample = floor(acc / 256), converted to sign-magnitude. acc>>>8 always
   // lies in -127..+127, so bits 14:8 carry the full two's-complement value
   // modulo 128 and negating them yields the magnitude; 0x80 cannot occur.
   function automatic logic [7:0] to_sm(input logic signed [16:0] a);
      logic [6:0] lo;
      lo = a[14:8];
      return a[16] ? {1'b1, 7'(~lo + 7'd1)} : {1'b0, lo};
   endfunction

   // NOTE: every next-state value gets its default before any branch, so the
   // combinational block can never infer a latch.
   always_comb begin
      state_d  = state;
      prev_d   = prev;
      cur_d    = cur;
      pend_d   = pend;
      pend_v_d = pend_v;
      k_d      = k;
      acc_d    = acc;
      hcnt_d   = hcnt;
      syn_d    = syn_out;
      dout_d   = data_out;
      ovf_d    = ovf;
      consume  = 1'b0;

      case (state)
         IDLE: begin
            syn_d = 1'b0;
            if (pend_v) begin
               consume = 1'b1;
               hcnt_d  = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (wrap) begin
               hcnt_d = '0;
               if (!syn_out) begin
                  syn_d = 1'b1;
               end else begin
                  // Falling edge: advance to the next sample of the frame.
                  syn_d = 1'b0;
                  if (k != 4'd15) begin
                     k_d    = k + 4'd1;
                     acc_d  = acc_step;
                     dout_d = to_sm(acc_step);
                  end else if (pend_v) begin
                     consume = 1'b1;      // seamless start of next frame
                  end else begin
                     state_d = IDLE;      // data_out keeps s_15
                  end
               end
            end else begin
               hcnt_d = hcnt + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (consume) begin
         prev_d   = cur;
         cur_d    = signed'(pend);
         k_d      = '0;
         acc_d    = acc_load;
         dout_d   = to_sm(acc_load);
         pend_v_d = 1'b0;
      end

      // A strobe in the consuming cycle refills the pending slot without loss.
      if (syn_in) begin
         pend_d   = data_in;
         pend_v_d = 1'b1;
         if (pend_v && !consume)
            ovf_d = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state    <= IDLE;
         prev     <= '0;
         cur      <= '0;
         pend     <= '0;
         pend_v   <= 1'b0;
         k        <= '0;
         acc      <= '0;
         hcnt     <= '0;
         syn_out  <= 1'b0;
         data_out <= '0;
         ovf      <= 1'b0;
      end else begin
         state    <= state_d;
         prev     <= prev_d;
         cur      <= cur_d;
         pend     <= pend_d;
         pend_v   <= pend_v_d;
         k        <= k_d;
         acc      <= acc_d;
         hcnt     <= hcnt_d;
         syn_out  <= syn_d;
         data_out <= dout_d;
         ovf      <= ovf_d;
      end
   end

endmodule
